// File: rtl/imem_portb_arbiter_pkg.sv
// Shared widths, FSM state codes and grant indices for the instruction-RAM
// port-B arbiter.
package imem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t S_IDLE  = 2'd0;
  localparam arb_state_t S_DRAIN = 2'd1;
  localparam arb_state_t S_LOAD  = 2'd2;
  localparam arb_state_t S_FLUSH = 2'd3;

  // Requester slots on the round-robin arbiter
  localparam int GNT_LD  = 0;
  localparam int GNT_DBG = 1;

endpackage

// File: rtl/imem_portb_arbiter_if.sv
// Loader, debugger, RAM port-B and CPU front-end signals of the port-B arbiter.
// The arbiter takes the slave modport; its environment takes the master modport.
interface imem_portb_arbiter_if
  import imem_arb_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W,
  parameter int BW = BE_W
);
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic [BW-1:0] ld_be;
  logic          ld_last;
  logic          ld_gnt;
  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] A2;
  logic [DW-1:0] WD2;
  logic [BW-1:0] WE2;
  logic [DW-1:0] RD2;
  logic          cpu_stall;
  logic          cpu_flush;

  modport slave (
    input  ld_req, ld_addr, ld_wdata, ld_be, ld_last, dbg_req, dbg_addr, RD2,
    output ld_gnt, dbg_gnt, dbg_rvalid, dbg_rdata, A2, WD2, WE2, cpu_stall, cpu_flush
  );

  modport master (
    output ld_req, ld_addr, ld_wdata, ld_be, ld_last, dbg_req, dbg_addr, RD2,
    input  ld_gnt, dbg_gnt, dbg_rvalid, dbg_rdata, A2, WD2, WE2, cpu_stall, cpu_flush
  );

endinterface

// File: rtl/imem_portb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // prio_q = 0 favours req[0], 1 favours req[1]
  logic prio_q, prio_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt[0])      prio_d = 1'b1;
    else if (gnt[1]) prio_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/imem_portb_arbiter.sv
// Shares instruction-RAM port B between the program loader and the debugger,
// and stalls then flushes the CPU front end around each load session.
module imem_portb_arbiter
  import imem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  imem_portb_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  logic [1:0]        req, gnt;
  logic [ADDR_W-1:0] a2_q, a2_d;
  logic [DATA_W-1:0] wd2;
  logic [BE_W-1:0]   we2;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Loader only competes once the front end is stalled; nobody touches the RAM while flushing
  assign req[GNT_LD]  = bus.ld_req  && (state_q == S_LOAD);
  assign req[GNT_DBG] = bus.dbg_req && (state_q != S_FLUSH);

  rr_arbiter2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (~rst),
    .gnt (gnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.ld_req) state_d = S_DRAIN;
      S_DRAIN: state_d = S_LOAD;
      S_LOAD:  if (gnt[GNT_LD] && bus.ld_last) state_d = S_FLUSH;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a2_d = a2_q;
    wd2  = '0;
    we2  = '0;
    if (gnt[GNT_LD]) begin
      a2_d = bus.ld_addr;
      wd2  = bus.ld_wdata;
      we2  = bus.ld_be;
    end else if (gnt[GNT_DBG]) begin
      a2_d = bus.dbg_addr;
    end
  end

  // RD2 is live only in the cycle after a debug grant; otherwise replay the last read
  assign rvalid_d = gnt[GNT_DBG];
  assign rdata_d  = rvalid_q ? bus.RD2 : rdata_q;

  assign bus.ld_gnt     = gnt[GNT_LD];
  assign bus.dbg_gnt    = gnt[GNT_DBG];
  assign bus.A2         = a2_d;
  assign bus.WD2        = wd2;
  assign bus.WE2        = we2;
  assign bus.dbg_rvalid = rvalid_q;
  assign bus.dbg_rdata  = rdata_d;
  assign bus.cpu_stall  = (state_q != S_IDLE);
  assign bus.cpu_flush  = (state_q == S_FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a2_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      a2_q     <= a2_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_imem_portb_arbiter.sv
// Directed and random checks of the port-B arbiter against a session-level
// reference model with its own shadow copy of the instruction RAM.
module tb_imem_portb_arbiter;

  localparam int P_IDLE  = 0;
  localparam int P_DRAIN = 1;
  localparam int P_LOAD  = 2;
  localparam int P_FLUSH = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_portb_arbiter_if bus ();

  imem_portb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Port-B RAM: byte-enabled, write-first, one-cycle registered read
  logic [31:0] ram [0:255];
  logic [31:0] ram_merged;
  always_comb begin
    ram_merged = ram[bus.A2[9:2]];
    for (int b = 0; b < 4; b++)
      if (bus.WE2[b]) ram_merged[8*b +: 8] = bus.WD2[8*b +: 8];
  end
  always @(posedge clk) begin
    ram[bus.A2[9:2]] <= ram_merged;
    bus.RD2          <= ram_merged;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          phase;
  bit          last_was_ld;
  logic [31:0] last_a2, last_rdata, rd_data;
  bit          rd_pend;
  logic [31:0] shadow [0:255];
  bit          exp_ld_win, exp_dbg_win;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase       = P_IDLE;
    last_was_ld = 1'b0;
    last_a2     = '0;
    last_rdata  = '0;
    rd_pend     = 1'b0;
    rd_data     = '0;
  endtask

  // One clock: check outputs at negedge, advance the model at posedge
  task automatic cycle();
    bit ld_el, dbg_el;
    logic [31:0] exp_a2;
    @(negedge clk);
    ld_el       = (phase == P_LOAD) && bus.ld_req;
    dbg_el      = (phase != P_FLUSH) && bus.dbg_req;
    exp_ld_win  = ld_el && (!dbg_el || !last_was_ld);
    exp_dbg_win = dbg_el && !exp_ld_win;
    exp_a2      = exp_ld_win ? bus.ld_addr : (exp_dbg_win ? bus.dbg_addr : last_a2);
    chk("ld_gnt", bus.ld_gnt, exp_ld_win);
    chk("dbg_gnt", bus.dbg_gnt, exp_dbg_win);
    chk("gnt_exclusive", bus.ld_gnt & bus.dbg_gnt, 0);
    chk("cpu_stall", bus.cpu_stall, phase != P_IDLE);
    chk("cpu_flush", bus.cpu_flush, phase == P_FLUSH);
    chk("we2", bus.WE2, exp_ld_win ? bus.ld_be : 4'h0);
    chk("a2", bus.A2, exp_a2);
    if (exp_ld_win) chk("wd2", bus.WD2, bus.ld_wdata);
    chk("dbg_rvalid", bus.dbg_rvalid, rd_pend);
    chk("dbg_rdata", bus.dbg_rdata, rd_pend ? rd_data : last_rdata);
    $display("t=%0t phase=%0d ld_req=%0b dbg_req=%0b ld_gnt=%0b dbg_gnt=%0b A2=%h WE2=%h rvalid=%0b rdata=%h",
             $time, phase, bus.ld_req, bus.dbg_req, bus.ld_gnt, bus.dbg_gnt, bus.A2, bus.WE2,
             bus.dbg_rvalid, bus.dbg_rdata);
    @(posedge clk);
    if (exp_ld_win) begin
      for (int b = 0; b < 4; b++)
        if (bus.ld_be[b]) shadow[bus.ld_addr[9:2]][8*b +: 8] = bus.ld_wdata[8*b +: 8];
      last_was_ld = 1'b1;
    end
    if (exp_dbg_win) last_was_ld = 1'b0;
    last_a2 = exp_a2;
    if (rd_pend) last_rdata = rd_data;
    rd_pend = exp_dbg_win;
    if (exp_dbg_win) rd_data = shadow[bus.dbg_addr[9:2]];
    case (phase)
      P_IDLE:  if (bus.ld_req) phase = P_DRAIN;
      P_DRAIN: phase = P_LOAD;
      P_LOAD:  if (exp_ld_win && bus.ld_last) phase = P_FLUSH;
      default: phase = P_IDLE;
    endcase
    #1;
  endtask

  task automatic wait_ld_gnt(input string tag);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!exp_ld_win && n < 20);
    chk(tag, n < 20, 1'b1);
  endtask

  task automatic set_ld(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic last);
    bus.ld_req   = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_wdata = data;
    bus.ld_be    = be;
    bus.ld_last  = last;
  endtask

  initial begin
    bit ld_hold, dbg_hold;
    int n;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = $urandom;
      shadow[i] = ram[i];
    end
    rst = 1'b1;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0; bus.ld_be = '0; bus.ld_last = 1'b0;
    bus.dbg_req = 1'b0; bus.dbg_addr = '0;
    model_reset();

    // Reset state
    #2;
    chk("rst_ld_gnt", bus.ld_gnt, 0);
    chk("rst_dbg_gnt", bus.dbg_gnt, 0);
    chk("rst_rvalid", bus.dbg_rvalid, 0);
    chk("rst_rdata", bus.dbg_rdata, 0);
    chk("rst_a2", bus.A2, 0);
    chk("rst_wd2", bus.WD2, 0);
    chk("rst_we2", bus.WE2, 0);
    chk("rst_stall", bus.cpu_stall, 0);
    chk("rst_flush", bus.cpu_flush, 0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;

    // Debug read while idle
    bus.dbg_req = 1'b1; bus.dbg_addr = 32'h10;
    cycle();
    bus.dbg_req = 1'b0;
    chk("idle_rd_rvalid", bus.dbg_rvalid, 1'b1);
    chk("idle_rd_data", bus.dbg_rdata, shadow[4]);
    cycle();

    // Three-write load session
    set_ld(32'h0, $urandom, 4'hF, 1'b0);
    cycle(); cycle(); cycle();
    set_ld(32'h4, $urandom, 4'hF, 1'b0);
    cycle();
    set_ld(32'h8, $urandom, 4'hF, 1'b1);
    cycle();
    bus.ld_req = 1'b0;
    cycle(); cycle();

    // Loader and debugger contending through a session
    set_ld({22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, 4'($urandom), 1'b0);
    bus.dbg_req = 1'b1; bus.dbg_addr = $urandom;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (exp_ld_win) set_ld({22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, 4'($urandom), 1'b0);
    end
    bus.dbg_req = 1'b0;
    bus.ld_last = 1'b1;
    wait_ld_gnt("contention_end");
    bus.ld_req = 1'b0;
    cycle(); cycle();

    // Read-after-write, then loader pause
    set_ld(32'h20, 32'hDEADBEEF, 4'hF, 1'b0);
    wait_ld_gnt("raw_write");
    bus.ld_req = 1'b0;
    bus.dbg_req = 1'b1; bus.dbg_addr = 32'h20;
    cycle();
    bus.dbg_req = 1'b0;
    chk("raw_data", bus.dbg_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) cycle();
    set_ld(32'h24, $urandom, 4'h0, 1'b1);
    wait_ld_gnt("pause_end");
    bus.ld_req = 1'b0;
    cycle(); cycle();

    // Random traffic obeying hold-until-grant
    ld_hold = 1'b0; dbg_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!ld_hold) begin
        set_ld({22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, 4'($urandom),
               $urandom_range(0, 3) == 0);
        bus.ld_req = ($urandom_range(0, 2) == 0);
        ld_hold    = bus.ld_req;
      end
      if (!dbg_hold) begin
        bus.dbg_req  = $urandom_range(0, 1);
        bus.dbg_addr = $urandom;
        dbg_hold     = bus.dbg_req;
      end
      cycle();
      if (exp_ld_win)  ld_hold  = 1'b0;
      if (exp_dbg_win) dbg_hold = 1'b0;
    end
    bus.dbg_req = 1'b0;
    n = 0;
    while (phase != P_IDLE && n < 50) begin
      bus.ld_req = (phase != P_FLUSH);
      bus.ld_last = 1'b1;
      cycle();
      n++;
    end
    chk("random_drain", n < 50, 1'b1);
    bus.ld_req = 1'b0;
    cycle();

    // Reset mid-LOAD with a read in flight
    set_ld(32'h40, $urandom, 4'hF, 1'b0);
    cycle(); cycle();
    bus.ld_req = 1'b0;
    bus.dbg_req = 1'b1; bus.dbg_addr = 32'h40;
    cycle();
    bus.dbg_req = 1'b0;
    bus.ld_req = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_stall", bus.cpu_stall, 0);
    chk("midrst_flush", bus.cpu_flush, 0);
    chk("midrst_we2", bus.WE2, 0);
    chk("midrst_ld_gnt", bus.ld_gnt, 0);
    chk("midrst_rvalid", bus.dbg_rvalid, 0);
    model_reset();
    @(posedge clk); #1;
    chk("midrst_flush2", bus.cpu_flush, 0);
    chk("midrst_stall2", bus.cpu_stall, 0);
    #2 rst = 1'b0;
    bus.ld_last = 1'b1;
    wait_ld_gnt("post_rst_session");
    bus.ld_req = 1'b0;
    cycle(); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
